// File: rtl/mux_n_to_1_stream.sv
// Registered N:1 channel selector with a valid/ready output handshake.
// Direct mode presents one selected channel per request. Scan mode streams
// channels 0..CHANNELS-1 in order, advancing one channel per accepted beat.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no request outstanding; Start is sampled here only
// S_VALID | Y/Y_ch/Err hold a beat waiting for the consumer (Busy=1)
module mux_n_to_1_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 32,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      Mode,
    input  logic                      Start,
    output logic [WIDTH-1:0]          Y,
    output logic [SEL_W-1:0]          Y_ch,
    output logic                      Y_valid,
    input  logic                      Y_ready,
    output logic                      Err,
    output logic                      Busy,
    output logic                      Done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    // One extra bit so the channel count itself is representable when
    // CHANNELS is a power of two.
    localparam logic [SEL_W:0]   CH_CNT  = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SEL_W-1:0] ych_q, ych_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [SEL_W-1:0] load_idx;
    logic [WIDTH-1:0] load_data;
    logic             sel_oor;

    assign sel_oor = ({1'b0, Sel} >= CH_CNT);

    // Channel mux; an index with no matching channel yields zero data.
    always_comb begin
        load_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (load_idx == SEL_W'(k)) begin
                load_data = I[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: request capture, beat acceptance and scan advance.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        y_d      = y_q;
        ych_d    = ych_q;
        err_d    = err_q;
        done_d   = 1'b0;
        load_idx = Sel;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d   = Mode;
                    load_idx = Mode ? '0 : Sel;
                    y_d      = load_data;
                    ych_d    = load_idx;
                    err_d    = ~Mode & sel_oor;
                    state_d  = S_VALID;
                end
            end
            S_VALID: begin
                if (Y_ready) begin
                    if (mode_q && (ych_q != LAST_CH)) begin
                        load_idx = ych_q + SEL_W'(1);
                        y_d      = load_data;
                        ych_d    = load_idx;
                        err_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            y_q     <= '0;
            ych_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            y_q     <= y_d;
            ych_q   <= ych_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign Y       = y_q;
    assign Y_ch    = ych_q;
    assign Err     = err_q;
    assign Busy    = (state_q == S_VALID);
    assign Y_valid = (state_q == S_VALID);
    assign Done    = done_q;

endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Directed bench for mux_n_to_1_stream: a 32x8 instance for the main
// scenarios and a 6x12 instance for out-of-range selects.
module tb_mux_n_to_1_stream;

    logic         clk;
    logic         rst;
    logic [255:0] I;
    logic [4:0]   Sel;
    logic         Mode;
    logic         Start;
    logic [7:0]   Y;
    logic [4:0]   Y_ch;
    logic         Y_valid;
    logic         Y_ready;
    logic         Err;
    logic         Busy;
    logic         Done;

    logic [71:0]  e_I;
    logic [2:0]   e_Sel;
    logic         e_Mode;
    logic         e_Start;
    logic [11:0]  e_Y;
    logic [2:0]   e_Y_ch;
    logic         e_Y_valid;
    logic         e_Y_ready;
    logic         e_Err;
    logic         e_Busy;
    logic         e_Done;

    int pass_cnt;
    int chk_cnt;

    mux_n_to_1_stream #(.WIDTH(8), .CHANNELS(32)) dut (
        .clk(clk), .rst(rst), .I(I), .Sel(Sel), .Mode(Mode), .Start(Start),
        .Y(Y), .Y_ch(Y_ch), .Y_valid(Y_valid), .Y_ready(Y_ready),
        .Err(Err), .Busy(Busy), .Done(Done)
    );

    mux_n_to_1_stream #(.WIDTH(12), .CHANNELS(6)) dut_e (
        .clk(clk), .rst(rst), .I(e_I), .Sel(e_Sel), .Mode(e_Mode), .Start(e_Start),
        .Y(e_Y), .Y_ch(e_Y_ch), .Y_valid(e_Y_valid), .Y_ready(e_Y_ready),
        .Err(e_Err), .Busy(e_Busy), .Done(e_Done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_base();
        for (int k = 0; k < 32; k++) I[k*8 +: 8] = 8'(k + 'h40);
    endtask

    task automatic test_reset();
        rst = 1'b1; Start = 1'b0; Mode = 1'b0; Sel = '0; Y_ready = 1'b0;
        e_Start = 1'b0; e_Mode = 1'b0; e_Sel = '0; e_Y_ready = 1'b0;
        load_base();
        for (int k = 0; k < 6; k++) e_I[k*12 +: 12] = 12'(k + 'h100);
        #12;
        chk_cnt++;
        if ({Y, Y_ch, Y_valid, Err, Busy, Done} !== 17'd0)
            $display("FAIL reset_outputs: got %h exp 0", {Y, Y_ch, Y_valid, Err, Busy, Done});
        else pass_cnt++;
        rst = 1'b0;
        step();
        chk_cnt++;
        if ({Y_valid, Busy, Done} !== 3'b000)
            $display("FAIL reset_idle: got %b exp 000", {Y_valid, Busy, Done});
        else pass_cnt++;
    endtask

    task automatic test_direct();
        Mode = 1'b0; Sel = 5'd5; Y_ready = 1'b1; Start = 1'b1;
        step();
        Start = 1'b0;
        chk_cnt++;
        if ({Y, Y_ch, Y_valid, Err} !== {8'h45, 5'd5, 1'b1, 1'b0})
            $display("FAIL direct_beat: got Y=%h ch=%0d v=%b err=%b exp Y=45 ch=5 v=1 err=0",
                     Y, Y_ch, Y_valid, Err);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({Done, Busy, Y_valid} !== 3'b100)
            $display("FAIL direct_done: got done/busy/valid=%b exp 100", {Done, Busy, Y_valid});
        else pass_cnt++;
        step();
        chk_cnt++;
        if (Done !== 1'b0) $display("FAIL direct_done_pulse: got %b exp 0", Done);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        Mode = 1'b0; Sel = 5'd31; Y_ready = 1'b0; Start = 1'b1;
        step();
        Start = 1'b0;
        I[31*8 +: 8] = 8'hAA;
        Sel = 5'd3;
        for (int c = 0; c < 4; c++) begin
            chk_cnt++;
            if ({Y, Y_ch, Y_valid} !== {8'h5F, 5'd31, 1'b1})
                $display("FAIL bp_hold%0d: got Y=%h ch=%0d v=%b exp Y=5f ch=31 v=1",
                         c, Y, Y_ch, Y_valid);
            else pass_cnt++;
            if (c < 3) step();
        end
        Y_ready = 1'b1;
        step();
        chk_cnt++;
        if ({Done, Busy, Y} !== {1'b1, 1'b0, 8'h5F})
            $display("FAIL bp_done: got done=%b busy=%b Y=%h exp 1 0 5f", Done, Busy, Y);
        else pass_cnt++;
        step();
        load_base();
    endtask

    task automatic test_scan_toggle();
        int beats;
        int dones;
        bit finished;
        for (int k = 0; k < 32; k++) I[k*8 +: 8] = 8'(k) ^ 8'hA5;
        beats = 0; dones = 0; finished = 0;
        Mode = 1'b1; Start = 1'b1; Y_ready = 1'b0;
        step();
        Start = 1'b0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            Y_ready = (cyc % 2 == 0);
            if (Done === 1'b1) begin
                dones++;
                finished = 1;
            end else if (Y_valid && Y_ready) begin
                chk_cnt++;
                if ({Y_ch, Y} !== {5'(beats), 8'(beats) ^ 8'hA5})
                    $display("FAIL scan_beat%0d: got ch=%0d Y=%h exp ch=%0d Y=%h",
                             beats, Y_ch, Y, beats, 8'(beats) ^ 8'hA5);
                else pass_cnt++;
                beats++;
            end
            if (!finished) step();
        end
        chk_cnt++;
        if (!finished || beats != 32)
            $display("FAIL scan_count: got beats=%0d done_seen=%0d exp 32 1", beats, finished);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({Done, Busy} !== 2'b00)
            $display("FAIL scan_single_done: got done/busy=%b exp 00", {Done, Busy});
        else pass_cnt++;
        load_base();
    endtask

    task automatic test_back_to_back();
        Mode = 1'b1; Start = 1'b1; Y_ready = 1'b1;
        step();
        Mode = 1'b0; Sel = 5'd3;
        for (int i = 0; i < 32; i++) begin
            chk_cnt++;
            if ({Y_valid, Y_ch, Y} !== {1'b1, 5'(i), 8'(i + 'h40)})
                $display("FAIL b2b_beat%0d: got v=%b ch=%0d Y=%h exp v=1 ch=%0d Y=%h",
                         i, Y_valid, Y_ch, Y, i, 8'(i + 'h40));
            else pass_cnt++;
            step();
        end
        Start = 1'b0;
        chk_cnt++;
        if ({Done, Y_valid, Busy} !== 3'b100)
            $display("FAIL b2b_done: got done/valid/busy=%b exp 100", {Done, Y_valid, Busy});
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({Done, Busy} !== 2'b00)
            $display("FAIL b2b_no_restart: got done/busy=%b exp 00", {Done, Busy});
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        e_Mode = 1'b0; e_Sel = 3'd7; e_Y_ready = 1'b0; e_Start = 1'b1;
        step();
        e_Start = 1'b0;
        chk_cnt++;
        if ({e_Y, e_Y_ch, e_Err, e_Y_valid} !== {12'h000, 3'd7, 1'b1, 1'b1})
            $display("FAIL oor_beat: got Y=%h ch=%0d err=%b v=%b exp 000 7 1 1",
                     e_Y, e_Y_ch, e_Err, e_Y_valid);
        else pass_cnt++;
        e_Y_ready = 1'b1;
        step();
        step();
        chk_cnt++;
        if ({e_Err, e_Busy} !== 2'b10)
            $display("FAIL oor_idle_hold: got err/busy=%b exp 10", {e_Err, e_Busy});
        else pass_cnt++;
        e_Sel = 3'd2; e_Start = 1'b1;
        step();
        e_Start = 1'b0;
        chk_cnt++;
        if ({e_Y, e_Y_ch, e_Err, e_Y_valid} !== {12'h102, 3'd2, 1'b0, 1'b1})
            $display("FAIL oor_clear: got Y=%h ch=%0d err=%b v=%b exp 102 2 0 1",
                     e_Y, e_Y_ch, e_Err, e_Y_valid);
        else pass_cnt++;
        step();
        e_Sel = 3'd5; e_Start = 1'b1;
        step();
        e_Start = 1'b0;
        chk_cnt++;
        if ({e_Y, e_Y_ch, e_Err} !== {12'h105, 3'd5, 1'b0})
            $display("FAIL oor_last_ch: got Y=%h ch=%0d err=%b exp 105 5 0", e_Y, e_Y_ch, e_Err);
        else pass_cnt++;
        step();
        e_Sel = 3'd6; e_Start = 1'b1;
        step();
        e_Start = 1'b0;
        chk_cnt++;
        if ({e_Y, e_Y_ch, e_Err} !== {12'h000, 3'd6, 1'b1})
            $display("FAIL oor_boundary: got Y=%h ch=%0d err=%b exp 000 6 1", e_Y, e_Y_ch, e_Err);
        else pass_cnt++;
        step();
    endtask

    task automatic test_async_reset();
        bit finished;
        Mode = 1'b1; Start = 1'b1; Y_ready = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk_cnt++;
        if ({Y_ch, Y} !== {5'd10, 8'h4A})
            $display("FAIL ar_pre: got ch=%0d Y=%h exp 10 4a", Y_ch, Y);
        else pass_cnt++;
        #3;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({Y, Y_ch, Y_valid, Err, Busy, Done} !== 17'd0)
            $display("FAIL ar_clear: got %h exp 0", {Y, Y_ch, Y_valid, Err, Busy, Done});
        else pass_cnt++;
        #1;
        rst = 1'b0;
        step();
        chk_cnt++;
        if (Busy !== 1'b0) $display("FAIL ar_idle: got busy=%b exp 0", Busy);
        else pass_cnt++;
        Mode = 1'b1; Start = 1'b1;
        step();
        Start = 1'b0;
        chk_cnt++;
        if ({Y_valid, Y_ch, Y} !== {1'b1, 5'd0, 8'h40})
            $display("FAIL ar_restart: got v=%b ch=%0d Y=%h exp 1 0 40", Y_valid, Y_ch, Y);
        else pass_cnt++;
        finished = 0;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            step();
            if (Done === 1'b1) finished = 1;
        end
        chk_cnt++;
        if (!finished) $display("FAIL ar_finish: got done_seen=0 exp 1");
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        test_reset();
        test_direct();
        test_backpressure();
        test_scan_toggle();
        test_back_to_back();
        test_out_of_range();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_stream.md
# mux_n_to_1_stream

Parametrised, registered N:1 channel selector with a valid/ready output handshake. It generalises the team's fixed 32:1 8-bit combinational mux in three ways: data width and channel count are parameters, the output is registered, and a scan mode streams every channel in order. It sits between the register-file/operand banks and any consumer that needs one channel per request, or a full sweep of all channels for dump and debug.

## Interface
Parameters:
- WIDTH, 8: bits per channel.
- CHANNELS, 32: number of input channels (≥2; need not be a power of two).
- SEL_W, $clog2(CHANNELS): select and channel-index width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous, active-high.
- I  input  CHANNELS*WIDTH  flattened inputs; channel k occupies I[k*WIDTH +: WIDTH].
- Sel  input  SEL_W  channel index for direct mode.
- Mode  input  1  0 = direct (single channel); 1 = scan (channels 0..CHANNELS-1).
- Start  input  1  request; sampled only in IDLE.
- Y  output  WIDTH  registered selected data.
- Y_ch  output  SEL_W  index of the channel currently held in Y.
- Y_valid  output  1  Y, Y_ch and Err are valid.
- Y_ready  input  1  consumer accepts when high together with Y_valid.
- Err  output  1  current Y came from an out-of-range index.
- Busy  output  1  state is not IDLE.
- Done  output  1  one-cycle pulse when a request completes.

## Operation
- States: IDLE and VALID. Busy = (state == VALID).
- IDLE with Start=1:
  - Latch Mode into an internal mode register.
  - Direct mode: load index Sel.
  - Scan mode: load index 0.
  - Register Y = I[index] and Y_ch = index.
  - Enter VALID.
- IDLE with Start=0: hold. Y, Y_ch and Err keep their last values; Y_valid stays 0.
- VALID with Y_ready=0: hold Y, Y_ch and Err stable. Inputs I and Sel may change freely; they are not re-sampled.
- VALID with Y_ready=1 (accept):
  - Direct mode: go to IDLE and pulse Done.
  - Scan mode, Y_ch < CHANNELS-1: stay in VALID, set Y_ch = Y_ch+1, and set Y = I[Y_ch+1] sampled this cycle. This gives back-to-back throughput of one channel per cycle.
  - Scan mode, Y_ch == CHANNELS-1: go to IDLE and pulse Done.
- Out-of-range index (Sel ≥ CHANNELS, direct mode only):
  - Y = 0, Y_ch = Sel, Err = 1 with Y_valid.
  - Err clears on the next load or on reset.
  - In scan mode Err is always 0.
- Start while Busy is ignored. Mode and Sel changes while Busy have no effect.
- Start on the same cycle as the final accept is ignored. A new request needs Start in a later IDLE cycle.
- Reset, asynchronous and at any time including mid-scan:
  - State goes to IDLE.
  - Y=0, Y_ch=0, Y_valid=0, Err=0, Busy=0, Done=0.
  - The internal mode register resets to 0.
- Y_valid is registered and equals Busy. Done is registered.

## Timing
- Start sampled high in IDLE at edge t:
  - Y_valid=1 and Y=I[index as sampled at t] from t+1.
  - Latency is one cycle.
- Accept at edge t (Y_valid & Y_ready):
  - Scan mode: the next channel is presented from t+1.
  - Final accept: Busy=0, Y_valid=0 and Done=1 from t+1 for exactly one cycle.
- A full scan with Y_ready held high takes CHANNELS cycles from the first Y_valid. Done follows in the cycle after the last beat.
- The consumer may deassert Y_ready for any number of cycles. No beat is lost or duplicated.
- Y stays unchanged while Y_valid=1 and Y_ready=0, even if I changes.

## Test plan
- Reset, then direct mode: set I channel k = k+8'h40, Sel=5, Start pulse with Y_ready=1.
  - Cycle after Start: Y=8'h45, Y_ch=5, Y_valid=1.
  - Next cycle: Done=1, Busy=0.
- Backpressure: direct mode Sel=31, Y_ready=0 for 4 cycles, and change I[31] mid-hold.
  - Y holds the originally sampled value.
  - Accept on cycle 5 ends the request; Done follows.
- Scan mode with Y_ready toggling 1,0,1,0…:
  - Exactly 32 beats, Y_ch 0..31 in order, with Y = that channel's value at load time.
  - Single Done after beat 31; no duplicates.
- Scan mode with Y_ready=1 continuously:
  - 32 consecutive valid cycles.
  - Start pulses during Busy are ignored.
- CHANNELS=6, WIDTH=12, direct mode Sel=7:
  - Y=12'h000, Y_ch=7, Err=1, Y_valid=1.
  - The next valid request with Sel=2 clears Err.
- Assert rst asynchronously mid-scan at Y_ch=10:
  - All outputs go to 0 immediately.
  - A fresh scan restarts at channel 0.
